// File: rtl/vec_mul_pkg.sv
// Shared types and helpers for the pipelined Vedic vector multiplier.
package vec_mul_pkg;

  localparam int MAX_XLEN = 64;

  typedef enum logic [1:0] {P8, P16, P32, P64} precision_e;
  typedef enum logic [1:0] {MUL, MULH, MULHU, MULSU} opcode_e;

  function automatic int lane_width(precision_e p);
    return 8 << int'(p);
  endfunction

endpackage

// File: rtl/vec_lane_mul_core.sv
// Combinational per-lane multiplier: sign-magnitude conversion, 8x8 Vedic partial
// products summed per lane, then conditional negation of each 2W-bit lane product.
module vec_lane_mul_core
  import vec_mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  precision_e        precision,
  input  logic              sign_a,
  input  logic              sign_b,
  output logic [2*XLEN-1:0] prod
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [NB-1:0]     neg_p;
  logic [2*XLEN-1:0] raw;
  int                lb;

  // Urdhva-Tiryakbhyam: vertical-and-crosswise column sums, each weighted by 2^s.
  function automatic logic [15:0] vedic8(logic [7:0] x, logic [7:0] y);
    logic [15:0] acc;
    logic [3:0]  col;
    acc = '0;
    for (int s = 0; s < 15; s++) begin
      col = '0;
      for (int i = 0; i < 8; i++) begin
        if ((s - i >= 0) && (s - i < 8)) col = col + 4'(x[i] & y[s-i]);
      end
      acc = acc + ({12'b0, col} << s);
    end
    return acc;
  endfunction

  // Lane size in bytes, clamped so an unsupported width never indexes past the operand.
  always_comb begin
    lb = lane_width(precision) / 8;
    if (lb > NB) lb = NB;
  end

  always_comb begin
    int   top;
    logic na, nb, ca, cb;
    logic [7:0] sa, sb;
    mag_a = '0;
    mag_b = '0;
    neg_p = '0;
    top = 0;
    na = 1'b0;
    nb = 1'b0;
    ca = 1'b0;
    cb = 1'b0;
    sa = '0;
    sb = '0;
    for (int r = 0; r < NB; r++) begin
      top = r | (lb - 1);
      na  = sign_a & a[8*top+7];
      nb  = sign_b & b[8*top+7];
      if ((r % lb) == 0) begin
        ca = 1'b1;
        cb = 1'b1;
        neg_p[r/lb] = na ^ nb;
      end
      {ca, sa} = {1'b0, ~a[8*r +: 8]} + {8'b0, ca};
      {cb, sb} = {1'b0, ~b[8*r +: 8]} + {8'b0, cb};
      mag_a[8*r +: 8] = na ? sa : a[8*r +: 8];
      mag_b[8*r +: 8] = nb ? sb : b[8*r +: 8];
    end
  end

  // Byte pair (i,j) of one lane lands at 8*(i+j) in the packed product; lanes cannot overlap.
  always_comb begin
    raw = '0;
    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j < NB; j++) begin
        if ((i / lb) == (j / lb)) begin
          raw = raw + ({{(2*XLEN-16){1'b0}}, vedic8(mag_a[8*i +: 8], mag_b[8*j +: 8])} << (8*(i+j)));
        end
      end
    end
  end

  always_comb begin
    logic c;
    logic [7:0] sp;
    prod = '0;
    c = 1'b0;
    sp = '0;
    for (int q = 0; q < 2*NB; q++) begin
      if ((q % (2*lb)) == 0) c = 1'b1;
      {c, sp} = {1'b0, ~raw[8*q +: 8]} + {8'b0, c};
      prod[8*q +: 8] = neg_p[q/(2*lb)] ? sp : raw[8*q +: 8];
    end
  end

endmodule

// File: rtl/vec_mul_pipe.sv
// Elastic, in-order vector multiply pipeline with tag passthrough between issue
// and writeback. Stage 0 holds full lane products; the half select feeds stage 1.
module vec_mul_pipe
  import vec_mul_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  operand_a,
  input  logic [XLEN-1:0]  operand_b,
  input  logic [1:0]       precision,
  input  logic [1:0]       opcode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high, on input and output alike; valid never waits for ready.

  precision_e        prec_in;
  opcode_e           op_in;
  logic              in_illegal;
  logic              sign_a, sign_b;
  logic [2*XLEN-1:0] core_prod;

  logic [STAGES-1:0] v_q, ill_q, adv;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [2*XLEN-1:0] prod_q;
  precision_e        prec_q;
  opcode_e           op_q;
  logic [XLEN-1:0]   sel0;

  assign prec_in    = precision_e'(precision);
  assign op_in      = opcode_e'(opcode);
  assign in_illegal = (XLEN < MAX_XLEN) && (prec_in == P64);
  assign sign_a     = (op_in == MULH) || (op_in == MULSU);
  assign sign_b     = (op_in == MULH);

  vec_lane_mul_core #(.XLEN(XLEN)) u_core (
    .a         (operand_a),
    .b         (operand_b),
    .precision (prec_in),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .prod      (core_prod)
  );

  function automatic logic [XLEN-1:0] pick_half(logic [2*XLEN-1:0] p, precision_e pr, opcode_e op);
    logic [XLEN-1:0] r;
    int lb, src;
    r  = '0;
    lb = lane_width(pr) / 8;
    if (lb > XLEN / 8) lb = XLEN / 8;
    for (int i = 0; i < XLEN / 8; i++) begin
      src = 2*lb*(i/lb) + (i % lb) + ((op == MUL) ? 0 : lb);
      r[8*i +: 8] = p[8*src +: 8];
    end
    return r;
  endfunction

  assign sel0 = pick_half(prod_q, prec_q, op_q);

  // Stall chain runs from the output back to the input so a full pipe still accepts
  // on the same edge it drains.
  always_comb begin
    logic go;
    adv = '0;
    go  = !v_q[STAGES-1] || out_ready;
    adv[STAGES-1] = go;
    for (int k = STAGES - 2; k >= 0; k--) begin
      go     = !v_q[k] || go;
      adv[k] = go;
    end
  end

  assign in_ready = rst && adv[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q    <= '0;
      ill_q  <= '0;
      prod_q <= '0;
      prec_q <= P8;
      op_q   <= MUL;
      for (int k = 0; k < STAGES; k++) tag_q[k] <= '0;
    end else begin
      if (adv[0]) begin
        v_q[0]   <= in_valid;
        ill_q[0] <= in_illegal;
        tag_q[0] <= in_tag;
        prod_q   <= in_illegal ? '0 : core_prod;
        prec_q   <= prec_in;
        op_q     <= op_in;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          v_q[k]   <= v_q[k-1];
          ill_q[k] <= ill_q[k-1];
          tag_q[k] <= tag_q[k-1];
        end
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_one
      assign result = sel0;
    end else begin : g_multi
      logic [XLEN-1:0] res_q [1:STAGES-1];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 1; k < STAGES; k++) res_q[k] <= '0;
        end else begin
          if (adv[1]) res_q[1] <= sel0;
          for (int k = 2; k < STAGES; k++) begin
            if (adv[k]) res_q[k] <= res_q[k-1];
          end
        end
      end
      assign result = res_q[STAGES-1];
    end
  endgenerate

  assign out_valid = v_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign illegal   = ill_q[STAGES-1];

endmodule
